// File: rtl/scsi_reg_access_ctl.sv
// ---------------------------------------------------------------------------
// ScsiRegAccessCtl : NCR register-access sequencer
//
// Sits between the Zorro III slave decoder and one or more NCR SCSI chips.
// An accepted bus access runs through two phases. In the address-strobe
// phase the controller asserts AS and waits a programmable setup time. In
// the select phase it asserts the chosen register select and DS, then waits
// for SLACK. When SLACK arrives, DTACK is returned to the bus side. A bad
// target select, or a SLACK that does not arrive in time, reports a bus
// error instead.
//
// Parameters
//   NUM_CS        number of register-select outputs (>=1)
//   AS_SETUP      clocks spent in the AS phase before select (0 acts as 1)
//   TIMEOUT_CLKS  clocks in the select phase before a bus error (0 = never)
//   MYBUS_CS      select index held low while the NCR owns the bus
//
// Ports
//   bclk         in   bus clock, rising edge
//   reset        in   synchronous, active-high
//   scsi_cycle   in   decoded SCSI access; low aborts / ends the cycle
//   cs_sel       in   one-hot target select, sampled at acceptance
//   DOE          in   data output enable from the bus
//   DS_n         in   byte strobes, active low
//   READ         in   1 = read, sampled at acceptance
//   mybus        in   NCR is bus master
//   SLACK_n      in   NCR slave acknowledge, active low
//   SCSI_SREG_n  out  register selects, active low
//   scsi_as_sig  out  address strobe to the NCR
//   scsi_ds_sig  out  data strobe to the NCR
//   dtack        out  cycle acknowledge to the bus side
//   berr         out  access error (bad select or SLACK timeout)
//   busy         out  sequencer not idle
// ---------------------------------------------------------------------------
module scsi_reg_access_ctl #(
    parameter int NUM_CS       = 2,
    parameter int AS_SETUP     = 1,
    parameter int TIMEOUT_CLKS = 64,
    parameter int MYBUS_CS     = 0
) (
    input  logic              bclk,
    input  logic              reset,
    input  logic              scsi_cycle,
    input  logic [NUM_CS-1:0] cs_sel,
    input  logic              DOE,
    input  logic [3:0]        DS_n,
    input  logic              READ,
    input  logic              mybus,
    input  logic              SLACK_n,
    output logic [NUM_CS-1:0] SCSI_SREG_n,
    output logic              scsi_as_sig,
    output logic              scsi_ds_sig,
    output logic              dtack,
    output logic              berr,
    output logic              busy
);

    // A zero setup time still needs one clock in the AS phase.
    localparam int SETUP_LOAD = (AS_SETUP < 1) ? 1 : AS_SETUP;
    localparam int SW         = $clog2(SETUP_LOAD + 1);

    // When the timeout is disabled, the counter still needs a legal width.
    // It then sits saturated and is never compared.
    localparam int TW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;

    localparam logic [SW-1:0]     SETUP_INIT  = SW'(SETUP_LOAD);
    localparam logic [TW-1:0]     TO_LIMIT    = TW'(TIMEOUT_CLKS);
    localparam logic [NUM_CS-1:0] SEL_NONE    = '1;
    localparam logic [NUM_CS-1:0] MYBUS_SELECT = ~(NUM_CS'(1) << MYBUS_CS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AS,
        S_CS,
        S_ACK,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [NUM_CS-1:0] r_sel;
    logic [SW-1:0]     r_setupCnt;
    logic [TW-1:0]     r_toCnt;
    logic [NUM_CS-1:0] r_sregN;
    logic              r_as;
    logic              r_ds;
    logic              r_dtack;
    logic              r_berr;
    logic              r_busy;

    logic              w_accept;
    logic              w_selOneHot;
    logic [TW-1:0]     w_toInc;
    logic              w_timeout;

    // An access starts only when the bus is really driving data strobes.
    // The abort and mybus conditions are handled ahead of the state case.
    assign w_accept    = DOE && !(&DS_n);
    assign w_selOneHot = $onehot(cs_sel);

    // The timeout counter saturates rather than wrapping. A very late SLACK
    // therefore can never look like a fresh count.
    assign w_toInc   = (r_toCnt == '1) ? r_toCnt : r_toCnt + TW'(1);
    assign w_timeout = (TIMEOUT_CLKS != 0) && (w_toInc == TO_LIMIT);

    // Single sequencer process. The outputs are set in the same branch that
    // picks the next state, so each output register shows the state being
    // entered on this edge.
    // Priority order: reset first, then scsi_cycle low (abort), then NCR bus
    // mastership, then the normal access flow.
    always_ff @(posedge bclk) begin
        if (reset || !scsi_cycle) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_setupCnt <= '0;
            r_toCnt    <= '0;
            r_sregN    <= SEL_NONE;
            r_as       <= 1'b0;
            r_ds       <= 1'b0;
            r_dtack    <= 1'b0;
            r_berr     <= 1'b0;
            r_busy     <= 1'b0;
        end else if (mybus) begin
            r_state    <= S_IDLE;
            r_setupCnt <= '0;
            r_toCnt    <= '0;
            r_sregN    <= MYBUS_SELECT;
            r_as       <= 1'b0;
            r_ds       <= 1'b0;
            r_dtack    <= 1'b0;
            r_berr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // An IDLE entered from the mybus state still holds that
                    // select. Release it here whenever no access starts.
                    r_sregN <= SEL_NONE;
                    if (w_accept) begin
                        r_sel  <= cs_sel;
                        r_busy <= 1'b1;
                        if (w_selOneHot) begin
                            r_state    <= S_AS;
                            r_setupCnt <= SETUP_INIT;
                            r_as       <= 1'b1;
                            // A read presents DS with AS. A write holds DS
                            // back until the select is asserted.
                            r_ds       <= READ;
                        end else begin
                            r_state <= S_ERR;
                            r_berr  <= 1'b1;
                        end
                    end
                end
                S_AS: begin
                    if (r_setupCnt <= SW'(1)) begin
                        r_state <= S_CS;
                        r_sregN <= ~r_sel;
                        r_ds    <= 1'b1;
                        r_toCnt <= '0;
                    end else begin
                        r_setupCnt <= r_setupCnt - SW'(1);
                    end
                end
                S_CS: begin
                    // If SLACK arrives on the same edge that the timeout
                    // expires, the cycle completes normally.
                    if (!SLACK_n) begin
                        r_state <= S_ACK;
                        r_dtack <= 1'b1;
                    end else begin
                        r_toCnt <= w_toInc;
                        if (w_timeout) begin
                            r_state <= S_ERR;
                            r_sregN <= SEL_NONE;
                            r_as    <= 1'b0;
                            r_ds    <= 1'b0;
                            r_berr  <= 1'b1;
                        end
                    end
                end
                S_ACK, S_ERR: begin
                    // Hold the current outputs until scsi_cycle drops.
                end
                default: begin
                    r_state <= S_IDLE;
                    r_sregN <= SEL_NONE;
                    r_as    <= 1'b0;
                    r_ds    <= 1'b0;
                    r_dtack <= 1'b0;
                    r_berr  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign SCSI_SREG_n = r_sregN;
    assign scsi_as_sig = r_as;
    assign scsi_ds_sig = r_ds;
    assign dtack       = r_dtack;
    assign berr        = r_berr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_scsi_reg_access_ctl.sv
// ---------------------------------------------------------------------------
// TbScsiRegAccessCtl : directed testbench for the NCR register sequencer
//
// Instance dutA uses the default parameters. Instance dutB shares the same
// inputs and uses AS_SETUP=3, which gives a longer address-strobe phase.
//
// Every step works the same way:
//   1. Drive the inputs.
//   2. Push the outputs expected after the next rising edge into a queue.
//   3. Wait for that edge.
//   4. Pop the expected value and compare it with the chosen DUT's outputs.
//
// Output vector layout: {SREG_n[1:0], as, ds, dtack, berr, busy}.
// ---------------------------------------------------------------------------
module tb_scsi_reg_access_ctl;

    logic       bclk = 1'b0;
    logic       reset;
    logic       scsi_cycle;
    logic [1:0] cs_sel;
    logic       DOE;
    logic [3:0] DS_n;
    logic       READ;
    logic       mybus;
    logic       SLACK_n;

    logic [1:0] sregA, sregB;
    logic       asA, dsA, dtackA, berrA, busyA;
    logic       asB, dsB, dtackB, berrB, busyB;

    logic [6:0] obsA, obsB;
    assign obsA = {sregA, asA, dsA, dtackA, berrA, busyA};
    assign obsB = {sregB, asB, dsB, dtackB, berrB, busyB};

    // Expected output vectors.
    localparam logic [6:0] IDLE_O  = 7'b11_00000;
    localparam logic [6:0] AS_RD_O = 7'b11_11001;
    localparam logic [6:0] AS_WR_O = 7'b11_10001;
    localparam logic [6:0] CS0_O   = 7'b10_11001;
    localparam logic [6:0] CS1_O   = 7'b01_11001;
    localparam logic [6:0] ACK0_O  = 7'b10_11101;
    localparam logic [6:0] ERR_O   = 7'b11_00011;
    localparam logic [6:0] MYBUS_O = 7'b10_00000;

    typedef struct {
        string      tag;
        logic [6:0] exp;
        bit         onB;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 bclk = ~bclk;

    scsi_reg_access_ctl #(
        .NUM_CS(2), .AS_SETUP(1), .TIMEOUT_CLKS(64), .MYBUS_CS(0)
    ) dutA (
        .bclk(bclk), .reset(reset), .scsi_cycle(scsi_cycle), .cs_sel(cs_sel),
        .DOE(DOE), .DS_n(DS_n), .READ(READ), .mybus(mybus), .SLACK_n(SLACK_n),
        .SCSI_SREG_n(sregA), .scsi_as_sig(asA), .scsi_ds_sig(dsA),
        .dtack(dtackA), .berr(berrA), .busy(busyA)
    );

    scsi_reg_access_ctl #(
        .NUM_CS(2), .AS_SETUP(3), .TIMEOUT_CLKS(64), .MYBUS_CS(0)
    ) dutB (
        .bclk(bclk), .reset(reset), .scsi_cycle(scsi_cycle), .cs_sel(cs_sel),
        .DOE(DOE), .DS_n(DS_n), .READ(READ), .mybus(mybus), .SLACK_n(SLACK_n),
        .SCSI_SREG_n(sregB), .scsi_as_sig(asB), .scsi_ds_sig(dsB),
        .dtack(dtackB), .berr(berrB), .busy(busyB)
    );

    // Drives the main cycle controls. DOE, DS_n, mybus and reset are set
    // directly by the steps that exercise them.
    task automatic applyStimulus(input logic sc, input logic rd,
                                 input logic [1:0] sel, input logic slackN);
        scsi_cycle = sc;
        READ       = rd;
        cs_sel     = sel;
        SLACK_n    = slackN;
    endtask

    // Pops the oldest expected entry and compares it with the chosen DUT.
    task automatic checkOutput();
        exp_t       item;
        logic [6:0] obs;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed no entry, expected one");
        end else begin
            item = sb.pop_front();
            obs  = item.onB ? obsB : obsA;
            assert (obs === item.exp) else begin
                errors++;
                $error("[TB] FAIL %s: observed %b expected %b", item.tag, obs, item.exp);
            end
        end
    endtask

    // Queues the expectation, waits one rising edge, then samples #1 later.
    task automatic expectNext(input string tag, input logic [6:0] e, input bit onB);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        item.onB = onB;
        sb.push_back(item);
        @(posedge bclk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset      = 1'b1;
        scsi_cycle = 1'b0;
        cs_sel     = 2'b00;
        DOE        = 1'b1;
        DS_n       = 4'h0;
        READ       = 1'b1;
        mybus      = 1'b0;
        SLACK_n    = 1'b1;

        $display("[TB] reset");
        expectNext("rst0", IDLE_O, 0);
        expectNext("rst1", IDLE_O, 0);
        reset = 1'b0;

        $display("[TB] read cycle with SLACK");
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
        expectNext("t1_as", AS_RD_O, 0);
        expectNext("t1_cs_entry", CS0_O, 0);
        expectNext("t1_cs_wait2", CS0_O, 0);
        expectNext("t1_cs_wait3", CS0_O, 0);
        SLACK_n = 1'b0;
        expectNext("t1_dtack", ACK0_O, 0);
        SLACK_n = 1'b1;
        expectNext("t1_ack_hold", ACK0_O, 0);
        scsi_cycle = 1'b0;
        expectNext("t1_idle", IDLE_O, 0);

        $display("[TB] write cycle with three-clock AS setup");
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b1);
        expectNext("t2_setup0", AS_WR_O, 1);
        expectNext("t2_setup1", AS_WR_O, 1);
        expectNext("t2_setup2", AS_WR_O, 1);
        expectNext("t2_cs_entry", CS1_O, 1);
        scsi_cycle = 1'b0;
        expectNext("t2_idle", IDLE_O, 1);

        $display("[TB] SLACK timeout");
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
        expectNext("t3_as", AS_RD_O, 0);
        expectNext("t3_cs_entry", CS0_O, 0);
        for (int i = 1; i < 64; i++) expectNext("t3_wait", CS0_O, 0);
        expectNext("t3_timeout", ERR_O, 0);
        DOE  = 1'b0;
        DS_n = 4'hF;
        expectNext("t3_err_hold", ERR_O, 0);
        scsi_cycle = 1'b0;
        DOE  = 1'b1;
        DS_n = 4'h0;
        expectNext("t3_berr_clear", IDLE_O, 0);

        $display("[TB] SLACK on the timeout edge");
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
        expectNext("t4_as", AS_RD_O, 0);
        expectNext("t4_cs_entry", CS0_O, 0);
        for (int i = 1; i < 64; i++) expectNext("t4_wait", CS0_O, 0);
        SLACK_n = 1'b0;
        expectNext("t4_slack_wins", ACK0_O, 0);
        SLACK_n = 1'b1;
        expectNext("t4_ack_hold", ACK0_O, 0);
        scsi_cycle = 1'b0;
        expectNext("t4_idle", IDLE_O, 0);

        $display("[TB] bad selects, mybus, no-accept cases");
        applyStimulus(1'b1, 1'b1, 2'b11, 1'b1);
        expectNext("t5_multi_err", ERR_O, 0);
        expectNext("t5_multi_hold", ERR_O, 0);
        scsi_cycle = 1'b0;
        expectNext("t5_multi_idle", IDLE_O, 0);
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
        expectNext("t5_zero_err", ERR_O, 0);
        scsi_cycle = 1'b0;
        expectNext("t5_zero_idle", IDLE_O, 0);
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
        mybus = 1'b1;
        expectNext("t5_mybus", MYBUS_O, 0);
        SLACK_n = 1'b0;
        expectNext("t5_mybus_slack", MYBUS_O, 0);
        mybus   = 1'b0;
        SLACK_n = 1'b1;
        scsi_cycle = 1'b0;
        expectNext("t5_mybus_exit", IDLE_O, 0);
        scsi_cycle = 1'b1;
        DS_n = 4'hF;
        expectNext("t5_no_strobe", IDLE_O, 0);
        DS_n = 4'h0;
        DOE  = 1'b0;
        expectNext("t5_no_doe", IDLE_O, 0);
        DOE = 1'b1;
        scsi_cycle = 1'b0;
        expectNext("t5_idle", IDLE_O, 0);

        $display("[TB] aborts and reset in ACK");
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
        expectNext("t6_as", AS_RD_O, 0);
        scsi_cycle = 1'b0;
        expectNext("t6_abort_as", IDLE_O, 0);
        scsi_cycle = 1'b1;
        expectNext("t6_as2", AS_RD_O, 0);
        expectNext("t6_cs", CS0_O, 0);
        expectNext("t6_cs_wait", CS0_O, 0);
        scsi_cycle = 1'b0;
        expectNext("t6_abort_cs", IDLE_O, 0);
        scsi_cycle = 1'b1;
        expectNext("t6_as3", AS_RD_O, 0);
        expectNext("t6_cs3", CS0_O, 0);
        SLACK_n = 1'b0;
        expectNext("t6_ack", ACK0_O, 0);
        reset = 1'b1;
        expectNext("t6_reset_ack", IDLE_O, 0);
        reset      = 1'b0;
        scsi_cycle = 1'b0;
        SLACK_n    = 1'b1;
        expectNext("t6_idle", IDLE_O, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
